conv_frame_ctrl: RTL
====================

// Module: conv_frame_ctrl
// PURPOSE
//  Frame sequencer for the padded 3x3 convolution datapath (line buffer + conv_mat).
//  - Accepts a per-frame configuration: kernel type and frame size.
//  - Gates a valid/ready pixel source into the datapath.
//  - Holds kernel_type and the frame sizes stable for the whole frame.
//  - Counts the results coming back and injects zero flush pixels until the frame completes.
//  - Reports done or timeout status.
// PARAMETERS
//  PIXEL_WIDTH    8     pixel width, same as the datapath
//  BUFFER_LENGTH  2000  maximum line length; size ports are $clog2(BUFFER_LENGTH) wide
//  FLUSH_MAX      4100  maximum zero pixels injected in DRAIN before timeout
// PORTS
//  clk             in   1                      clock
//  rst_n           in   1                      asynchronous active-low reset
//  cfg_start       in   1                      1-cycle pulse; sampled only in IDLE
//  cfg_kernel_type in   5                      kernel-bank index for the frame
//  cfg_col_size    in   $clog2(BUFFER_LENGTH)  frame columns; 0 is illegal
//  cfg_row_size    in   $clog2(BUFFER_LENGTH)  frame rows; 0 is illegal
//  src_pixel       in   PIXEL_WIDTH            source pixel
//  src_valid       in   1                      source pixel valid
//  src_ready       out  1                      controller accepts a source pixel
//  dp_in_point     out  PIXEL_WIDTH            to datapath in_point
//  dp_valid_in     out  1                      to datapath valid_in
//  dp_col_size     out  $clog2(BUFFER_LENGTH)  to frame_column_size (registered)
//  dp_row_size     out  $clog2(BUFFER_LENGTH)  to frame_row_size (registered)
//  dp_kernel_type  out  5                      to kernel_type (registered)
//  dp_valid_out    in   1                      datapath valid_out
//  busy            out  1                      high in any state except IDLE
//  frame_done      out  1                      1-cycle pulse; frame completed normally
//  frame_err       out  1                      1-cycle pulse; illegal config or flush timeout
// BEHAVIOUR
//  Reset (async): all outputs go to 0, state = IDLE, all counters = 0.
//  TOTAL = cfg_col_size * cfg_row_size, computed at full width 2*$clog2(BUFFER_LENGTH).
//  IDLE
//   - cfg_start with a size of 0: pulse frame_err, stay in IDLE.
//   - cfg_start otherwise: register kernel type and sizes into the dp_* outputs, go to LOAD.
//  LOAD: one cycle; clear in_cnt and out_cnt, go to STREAM.
//  STREAM
//   - src_ready = 1.
//   - On src_valid & src_ready (same cycle):
//     - dp_valid_in = 1 and dp_in_point = src_pixel, combinational pass-through, zero latency;
//     - in_cnt++.
//   - When the accepted pixel is number TOTAL: deassert src_ready from the next cycle and go to DRAIN.
//  DRAIN
//   - src_ready = 0.
//   - Drive dp_valid_in = 1 with dp_in_point = 0 on every cycle (zero flush for the bottom and right padding).
//   - Increment flush_cnt each cycle.
//  All states: every cycle with dp_valid_out high increments out_cnt, including during STREAM.
//  Leaving DRAIN
//   - out_cnt reaches TOTAL: go to DONE. Takes priority over the timeout.
//   - flush_cnt reaches FLUSH_MAX: pulse frame_err and go to IDLE.
//  DONE: pulse frame_done for one cycle, dp_valid_in = 0, go to IDLE.
//  Stability: dp_kernel_type and dp_size change only in IDLE->LOAD; a cfg_start while busy is ignored.
//  Extra results: dp_valid_out pulses after out_cnt == TOTAL are discarded and do not wrap the counter.
//  Reset mid-frame: immediate return to IDLE with all outputs at 0; no done or err pulse.
// CONFIGURATION
//  Macro CONV_CTRL_PERF_EN
//   - Defined: add output perf_cycles [31:0]. Cleared in LOAD, incremented every cycle in
//     STREAM and DRAIN, saturates at all-ones, holds its value until the next LOAD.
//     Also add output perf_stall [31:0], counting STREAM cycles with src_valid = 0.
//   - Undefined: neither port nor counter exists; all other behaviour is identical.
// STRUCTURE
//  Shared package conv_pkg:
//   - state enum {IDLE, LOAD, STREAM, DRAIN, DONE};
//   - kernel-type localparams (K_GAUSSIAN_BLUR_1, ...), moved from kernel_value.svh;
//   - KTYPE_W = 5.
//  Sub-module conv_frame_cnt: loadable up-counter with terminal-count compare.
//   - Instantiated three times: in_cnt, out_cnt, flush_cnt.
//   - Datapath instantiation stays in the top-level wrapper, outside this block.
// TESTING
//  1. 4x4 frame, src_valid held high, datapath model returns 16 valid_out
//     -> 16 pass-through cycles, src_ready low from cycle 17, exactly one frame_done, busy low after it.
//  2. 3x5 frame, src_valid toggling 1010...
//     -> dp_valid_in pulses only on handshakes, in_cnt = 15.
//     -> perf_stall = 14 with CONV_CTRL_PERF_EN defined.
//  3. cfg_col_size = 0, cfg_start pulse -> frame_err one cycle, busy stays 0, dp_* unchanged.
//  4. Model never returns valid_out, FLUSH_MAX = 8
//     -> exactly 8 zero flush pixels, frame_err pulse, back to IDLE.
//  5. cfg_start with kernel_type = 3 mid-frame -> ignored; dp_kernel_type keeps the original value until done.
//  6. rst_n low during DRAIN -> all outputs 0 asynchronously, no frame_done; a new 2x2 frame then completes normally.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution frame sequencer: FSM state
// encoding, kernel-bank indices and the kernel-type width.
package conv_pkg;

  localparam int unsigned KTYPE_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  // Kernel-bank indices selectable through cfg_kernel_type
  localparam logic [KTYPE_W-1:0] K_GAUSSIAN_BLUR_1 = 5'd0;
  localparam logic [KTYPE_W-1:0] K_GAUSSIAN_BLUR_2 = 5'd1;
  localparam logic [KTYPE_W-1:0] K_BOX_BLUR        = 5'd2;
  localparam logic [KTYPE_W-1:0] K_SHARPEN         = 5'd3;
  localparam logic [KTYPE_W-1:0] K_EDGE_DETECT_1   = 5'd4;
  localparam logic [KTYPE_W-1:0] K_EDGE_DETECT_2   = 5'd5;
  localparam logic [KTYPE_W-1:0] K_SOBEL_X         = 5'd6;
  localparam logic [KTYPE_W-1:0] K_SOBEL_Y         = 5'd7;
  localparam logic [KTYPE_W-1:0] K_EMBOSS          = 5'd8;

endpackage

// File: rtl/conv_frame_cnt.sv
// Loadable up-counter with terminal-count compare. Counting stops at the
// terminal value so surplus increments never wrap it.
module conv_frame_cnt
  import conv_pkg::*;
#(
  parameter int unsigned WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] term,
  output logic             at_term,
  output logic             last
);

  logic [WIDTH-1:0] count;

  assign at_term = (count == term);
  // One increment away from the terminal value
  assign last    = (count == term - WIDTH'(1));

  // Count up until the terminal value; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !at_term) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the padded 3x3 convolution datapath. Latches a
// per-frame configuration, gates the pixel source into the datapath, counts
// results and injects zero flush pixels until the frame completes.
// Optional build macro: CONV_CTRL_PERF_EN adds perf_cycles / perf_stall.
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH   = 8,
  parameter int unsigned BUFFER_LENGTH = 2000,
  parameter int unsigned FLUSH_MAX     = 4100
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_start,
  input  logic [KTYPE_W-1:0]               cfg_kernel_type,
  input  logic [$clog2(BUFFER_LENGTH)-1:0] cfg_col_size,
  input  logic [$clog2(BUFFER_LENGTH)-1:0] cfg_row_size,
  input  logic [PIXEL_WIDTH-1:0]           src_pixel,
  input  logic                             src_valid,
  output logic                             src_ready,
  output logic [PIXEL_WIDTH-1:0]           dp_in_point,
  output logic                             dp_valid_in,
  output logic [$clog2(BUFFER_LENGTH)-1:0] dp_col_size,
  output logic [$clog2(BUFFER_LENGTH)-1:0] dp_row_size,
  output logic [KTYPE_W-1:0]               dp_kernel_type,
  input  logic                             dp_valid_out,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             frame_err
`ifdef CONV_CTRL_PERF_EN
  ,
  output logic [31:0]                      perf_cycles,
  output logic [31:0]                      perf_stall
`endif
);

  localparam int unsigned SIZE_W  = $clog2(BUFFER_LENGTH);
  localparam int unsigned TOT_W   = 2 * SIZE_W;
  localparam int unsigned FLUSH_W = $clog2(FLUSH_MAX + 1);

  state_t           state;
  logic [TOT_W-1:0] total;
  logic             drain_q;
  logic             hs;
  logic             size_zero;
  logic             in_at_term, in_last;
  logic             out_at_term, out_last, out_reach;
  logic             flush_at_term, flush_last;

  assign hs        = src_valid & src_ready;
  assign size_zero = (cfg_col_size == '0) || (cfg_row_size == '0);

  // Source pixels pass straight through on a handshake; the flush phase
  // feeds zeros for the bottom and right padding.
  assign dp_valid_in = hs | drain_q;
  assign dp_in_point = hs ? src_pixel : '0;

  // A result arriving this cycle that completes the frame counts as reached,
  // so completion wins over a timeout landing on the same cycle.
  assign out_reach = out_at_term | (dp_valid_out & out_last);

  conv_frame_cnt #(
    .WIDTH (TOT_W)
  ) u_in_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == LOAD),
    .inc     (hs),
    .term    (total),
    .at_term (in_at_term),
    .last    (in_last)
  );

  conv_frame_cnt #(
    .WIDTH (TOT_W)
  ) u_out_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == LOAD),
    .inc     (dp_valid_out),
    .term    (total),
    .at_term (out_at_term),
    .last    (out_last)
  );

  conv_frame_cnt #(
    .WIDTH (FLUSH_W)
  ) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == LOAD),
    .inc     (state == DRAIN),
    .term    (FLUSH_W'(FLUSH_MAX)),
    .at_term (flush_at_term),
    .last    (flush_last)
  );

  // Frame FSM with registered handshake, status and configuration outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      total          <= '0;
      drain_q        <= 1'b0;
      src_ready      <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      frame_err      <= 1'b0;
      dp_col_size    <= '0;
      dp_row_size    <= '0;
      dp_kernel_type <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            if (size_zero) begin
              frame_err <= 1'b1;
            end else begin
              dp_kernel_type <= cfg_kernel_type;
              dp_col_size    <= cfg_col_size;
              dp_row_size    <= cfg_row_size;
              total          <= TOT_W'(cfg_col_size) * TOT_W'(cfg_row_size);
              busy           <= 1'b1;
              state          <= LOAD;
            end
          end
        end
        LOAD: begin
          src_ready <= 1'b1;
          state     <= STREAM;
        end
        STREAM: begin
          // Leave on the final accepted pixel; readiness drops from the next cycle
          if ((hs && in_last) || in_at_term) begin
            src_ready <= 1'b0;
            drain_q   <= 1'b1;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          // Timeout fires on the cycle that issues the last allowed flush pixel
          if (out_reach) begin
            drain_q    <= 1'b0;
            frame_done <= 1'b1;
            state      <= DONE;
          end else if (flush_last || flush_at_term) begin
            drain_q   <= 1'b0;
            frame_err <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          drain_q   <= 1'b0;
          src_ready <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef CONV_CTRL_PERF_EN
  // Saturating active-cycle and source-stall counters, restarted per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (state == LOAD) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (((state == STREAM) || (state == DRAIN)) && (perf_cycles != '1)) begin
        perf_cycles <= perf_cycles + 32'd1;
      end
      if ((state == STREAM) && !src_valid && (perf_stall != '1)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule
